y_demux1to4_buf: RTL and testbench



---
 rtl/y_demux1to4_buf.sv | 65 ++++++
 tb/tb_y_demux1to4_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/y_demux1to4_buf.sv
// Buffered 1-to-4 word demultiplexer. Each output channel has its own one-entry
// holding register, a valid/ready handshake and a wrapping delivered-word counter.
module y_demux1to4_buf #(
   parameter int SIZE  = 32,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SIZE-1:0]      in_data,
   input  logic [1:0]           in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [4*SIZE-1:0]    out_data,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   output logic [4*CNT_W-1:0]   out_count
);

   logic [3:0] accept;
   logic [3:0] consume;

   // NOTE: every always_comb target gets a default before any conditional or
   // indexed write, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      in_ready       = ~out_valid[in_sel] | out_ready[in_sel];
      accept         = '0;
      accept[in_sel] = in_valid & in_ready;
   end

   assign consume = out_valid & out_ready;

   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic             vld_q;
      logic [SIZE-1:0]  data_q;
      logic [CNT_W-1:0] cnt_q;

      // NOTE: sequential state is written only with non-blocking (<=) so every
      // register samples pre-edge values regardless of block evaluation order.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            // NOTE: the holding register is reset too: it is a single word, not
            // a memory array, and its value is visible on out_data after reset.
            vld_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
         end else begin
            // A same-cycle refill wins over the consume, so the channel never bubbles.
            if (accept[i]) begin
               data_q <= in_data;
               vld_q  <= 1'b1;
            end else if (consume[i]) begin
               vld_q  <= 1'b0;
            end
            if (consume[i]) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign out_valid[i]                  = vld_q;
      assign out_data[i*SIZE +: SIZE]      = data_q;
      assign out_count[i*CNT_W +: CNT_W]   = cnt_q;
   end

endmodule

// File: tb/tb_y_demux1to4_buf.sv
// Bench for y_demux1to4_buf: directed vector table, counter-wrap and reset
// sequences, and a constrained-random phase, all tracked by a per-channel scoreboard.
module tb_y_demux1to4_buf;

   localparam int SIZE  = 32;
   localparam int CNT_W = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [SIZE-1:0]     in_data;
   logic [1:0]          in_sel;
   logic                in_valid;
   logic                in_ready;
   logic [4*SIZE-1:0]   out_data;
   logic [3:0]          out_valid;
   logic [3:0]          out_ready;
   logic [4*CNT_W-1:0]  out_count;

   y_demux1to4_buf #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted words queue per channel; popped when the consumer takes them.
   logic [SIZE-1:0]  exp_q [4][$];
   logic [CNT_W-1:0] cnt_m [4];
   bit               model_on = 1'b0;

   always @(negedge clk) begin
      bit acc;
      if (model_on) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("sb_out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0)
               check($sformatf("sb_out_data[%0d]", i), 64'(out_data[i*SIZE +: SIZE]), 64'(exp_q[i][0]));
            check($sformatf("sb_out_count[%0d]", i), 64'(out_count[i*CNT_W +: CNT_W]), 64'(cnt_m[i]));
         end
         if (in_valid && rst_n)
            check("sb_in_ready", 64'(in_ready),
                  64'(exp_q[in_sel].size() == 0 || out_ready[in_sel]));
      end
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            cnt_m[i] = '0;
         end
         model_on = 1'b1;
      end else if (model_on) begin
         acc = in_valid && (exp_q[in_sel].size() == 0 || out_ready[in_sel]);
         for (int i = 0; i < 4; i++) begin
            if (exp_q[i].size() != 0 && out_ready[i]) begin
               void'(exp_q[i].pop_front());
               cnt_m[i] = cnt_m[i] + 1'b1;
            end
         end
         if (acc) exp_q[in_sel].push_back(in_data);
      end
   end

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [1:0]  sel;
      logic [31:0] data;
      logic [3:0]  ordy;
      logic        chk_ir;
      logic        exp_ir;
      logic [3:0]  exp_ov;
      logic [31:0] exp_cnt;   // {cnt3, cnt2, cnt1, cnt0}
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic iv, input logic [1:0] sel, input logic [31:0] d,
                      input logic [3:0] ordy, input logic chk, input logic ir,
                      input logic [3:0] ov, input logic [31:0] cnt);
      vec_t v;
      v = '{r, iv, sel, d, ordy, chk, ir, ov, cnt};
      vecs.push_back(v);
   endtask

   initial begin
      bit hold;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;

      // Reset held with a pending word and all consumers ready
      add(0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 0, 4'h0, 32'h0);
      add(0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 0, 4'h0, 32'h0);
      add(1, 1, 2, 32'hDEADBEEF, 4'hF, 1, 1, 4'h4, 32'h0);
      // Reset overrides the consume of DEADBEEF
      add(0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 0, 4'h0, 32'h0);
      // Basic routing
      add(1, 1, 0, 32'h11111111, 4'hF, 1, 1, 4'h1, 32'h00000000);
      add(1, 1, 1, 32'h22222222, 4'hF, 1, 1, 4'h2, 32'h00000001);
      add(1, 1, 2, 32'h33333333, 4'hF, 1, 1, 4'h4, 32'h00000101);
      add(1, 1, 3, 32'h44444444, 4'hF, 1, 1, 4'h8, 32'h00010101);
      add(1, 0, 0, 32'h0,        4'hF, 0, 0, 4'h0, 32'h01010101);
      add(0, 0, 0, 32'h0,        4'h0, 0, 0, 4'h0, 32'h0);
      // Stall isolation
      add(1, 1, 1, 32'hA, 4'b1101, 1, 1, 4'b0010, 32'h0);
      add(1, 1, 1, 32'hB, 4'b1101, 1, 0, 4'b0010, 32'h0);
      add(1, 1, 3, 32'hC, 4'b1101, 1, 1, 4'b1010, 32'h0);
      add(1, 0, 0, 32'h0, 4'b1101, 0, 0, 4'b0010, 32'h01000000);
      add(1, 0, 0, 32'h0, 4'b1101, 0, 0, 4'b0010, 32'h01000000);
      add(1, 0, 0, 32'h0, 4'b1111, 0, 0, 4'b0000, 32'h01000100);
      // Pass-through refill, then out_ready on empty channels
      add(1, 1, 0, 32'h5, 4'b0000, 1, 1, 4'b0001, 32'h01000100);
      add(1, 1, 0, 32'h6, 4'b0001, 1, 1, 4'b0001, 32'h01000101);
      add(1, 0, 0, 32'h0, 4'b0001, 0, 0, 4'b0000, 32'h01000102);
      add(1, 0, 0, 32'h0, 4'b1111, 0, 0, 4'b0000, 32'h01000102);
      // Reset mid-operation with ch0 and ch3 full and stalled
      add(1, 1, 0, 32'hAAAA0000, 4'h0, 1, 1, 4'b0001, 32'h01000102);
      add(1, 1, 3, 32'hBBBB0003, 4'h0, 1, 1, 4'b1001, 32'h01000102);
      add(1, 1, 0, 32'hCCCC0000, 4'h0, 1, 0, 4'b1001, 32'h01000102);
      add(0, 0, 0, 32'h0,        4'hF, 0, 0, 4'h0, 32'h0);
      add(1, 0, 0, 32'h0,        4'hF, 0, 0, 4'h0, 32'h0);

      #1;
      foreach (vecs[k]) begin
         rst_n = vecs[k].rst_n; in_valid = vecs[k].iv; in_sel = vecs[k].sel;
         in_data = vecs[k].data; out_ready = vecs[k].ordy;
         #2;
         if (vecs[k].chk_ir) check($sformatf("tbl_in_ready[%0d]", k), 64'(in_ready), 64'(vecs[k].exp_ir));
         @(posedge clk); #1;
         check($sformatf("tbl_out_valid[%0d]", k), 64'(out_valid), 64'(vecs[k].exp_ov));
         check($sformatf("tbl_out_count[%0d]", k), 64'(out_count), 64'(vecs[k].exp_cnt));
      end

      // Counter wrap: 256 back-to-back words into ch2
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1; in_sel = 2'd2; in_data = 32'(i); out_ready = 4'b0100;
         @(posedge clk); #1;
         if (i == 255) check("wrap_255", 64'(out_count), 64'h00FF0000);
      end
      in_valid = 1'b0; out_ready = 4'b0100;
      @(posedge clk); #1;
      check("wrap_0", 64'(out_count), 64'h0);
      check("wrap_empty", 64'(out_valid), 64'h0);

      // Randomized traffic; a refused word is held until accepted
      hold = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (!hold) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = $urandom;
         end
         out_ready = 4'($urandom);
         #2;
         hold = in_valid && !in_ready;
         @(posedge clk); #1;
      end

      // Drain
      in_valid = 1'b0; out_ready = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("drain_empty", 64'(out_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
